// File: rtl/axi_bus_arbiter_pkg.sv
// Shared types and constants for the AXI4-Lite requester arbiter.
package axi_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // Index width that stays legal when only one requester exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_bus_arbiter_if.sv
// AXI4-Lite master-port signal bundle; master drives address/data, slave drives ready/response.
interface axi_bus_arbiter_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic [2:0]  arprot;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic        awvalid;
    logic [2:0]  awprot;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, arprot, rready,
        output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, arprot, rready,
        input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/axi_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid bit strictly after the last-granted index.
module rr_arbiter
    import axi_bus_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDXW-1:0] last,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx
);

    logic            found;
    logic [IDXW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = last;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDXW'((32'(last) + i) % NREQ);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_bus_arbiter.sv
// Serialises NREQ valid/ready requesters onto one AXI4-Lite master port, one transaction at a time.
module axi_bus_arbiter
    import axi_bus_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    input  logic [NREQ*4-1:0]    req_wstrb,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    axi_bus_arbiter_if.master    axi
);

    localparam int unsigned IDXW = idx_width(NREQ);

    arb_state_t      state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;

    logic            arvalid_q, arvalid_d;
    logic [31:0]     araddr_q, araddr_d;
    logic            rready_q, rready_d;
    logic            awvalid_q, awvalid_d;
    logic [31:0]     awaddr_q, awaddr_d;
    logic            wvalid_q, wvalid_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            bready_q, bready_d;

    logic [NREQ-1:0] gnt_onehot;
    logic [IDXW-1:0] gnt_idx;
    bus_req_t        reqs [NREQ];
    bus_req_t        sel;
    logic            aw_done, w_done;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .valid (req_valid),
        .last  (ptr_q),
        .grant (gnt_onehot),
        .idx   (gnt_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            reqs[i].we    = req_we[i];
            reqs[i].addr  = req_addr[32*i +: 32];
            reqs[i].wdata = req_wdata[32*i +: 32];
            reqs[i].wstrb = req_wstrb[4*i +: 4];
        end
    end

    assign sel = reqs[gnt_idx];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        awaddr_d     = awaddr_q;
        wvalid_d     = wvalid_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bready_d     = bready_q;
        // A channel counts as done once its valid has already dropped or handshakes now.
        aw_done      = !awvalid_q || axi.awready;
        w_done       = !wvalid_q  || axi.wready;

        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    ptr_d       = gnt_idx;
                    req_ready_d = gnt_onehot;
                    if (sel.we) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        awaddr_d  = sel.addr;
                        wvalid_d  = 1'b1;
                        wdata_d   = sel.wdata;
                        wstrb_d   = sel.wstrb;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                        araddr_d  = sel.addr;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (arvalid_q && axi.arready) begin
                    arvalid_d = 1'b0;
                    araddr_d  = '0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rready_q && axi.rvalid) begin
                    rready_d     = 1'b0;
                    state_d      = ST_IDLE;
                    resp_valid_d = NREQ'(1) << ptr_q;
                    resp_rdata_d = axi.rdata;
                    resp_err_d   = (axi.rresp != AXI_RESP_OKAY);
                end
            end
            ST_WR_REQ: begin
                if (awvalid_q && axi.awready) begin
                    awvalid_d = 1'b0;
                    awaddr_d  = '0;
                end
                if (wvalid_q && axi.wready) begin
                    wvalid_d = 1'b0;
                    wdata_d  = '0;
                    wstrb_d  = '0;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bready_q && axi.bvalid) begin
                    bready_d     = 1'b0;
                    state_d      = ST_IDLE;
                    resp_valid_d = NREQ'(1) << ptr_q;
                    resp_err_d   = (axi.bresp != AXI_RESP_OKAY);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= '0;
            wvalid_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            awaddr_q     <= awaddr_d;
            wvalid_q     <= wvalid_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bready_q     <= bready_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;

    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.arprot  = AXI_PROT_DEFAULT;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.awprot  = AXI_PROT_DEFAULT;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Scoreboard bench: requester driver, AXI slave model with programmable wait states, response monitor.
module tb_axi_bus_arbiter;

    localparam int unsigned NREQ = 2;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*32-1:0]   req_addr;
    logic [NREQ*32-1:0]   req_wdata;
    logic [NREQ*4-1:0]    req_wstrb;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      resp_valid;
    logic [31:0]          resp_rdata;
    logic                 resp_err;

    axi_bus_arbiter_if axi ();

    axi_bus_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .axi        (axi)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
    } stim_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    stim_t       req_q [NREQ][$];
    exp_t        exp_q [NREQ][$];
    int unsigned resp_order [$];
    logic        busy [NREQ];
    logic        clr_next [NREQ];
    int          raise_cyc [NREQ];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [1:0]  slv_rresp = 2'b00, slv_bresp = 2'b00;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] rd_addr = '0, ar_addr0 = '0, seen_awaddr = '0, seen_wdata = '0;
    logic [3:0]  seen_wstrb = '0;
    logic        seen_aw_first = 1'b0, bready_prev = 1'b0;
    int          w_hold = 0, ar_hold = 0, ar_unstable = 0, rready_early = 0;
    int          hs_cyc = 0, bready_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar p = 0; p < NREQ; p++) begin : g_proto
        a_req_hold: assert property (@(posedge clk) disable iff (rst) $fell(req_valid[p]) |-> req_ready[p]);
    end

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'd1);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_req(input int p, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb, input int lat);
        stim_t s;
        s = '{we, addr, wdata, wstrb, lat};
        req_q[p].push_back(s);
    endtask

    function automatic logic all_idle();
        logic r;
        r = (req_valid == '0);
        for (int unsigned p = 0; p < NREQ; p++)
            if (req_q[p].size() != 0 || exp_q[p].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_eq("idle_reached", 64'(n < budget), 64'd1);
        repeat (2) @(posedge clk);
    endtask

    task automatic flush_bench();
        for (int unsigned p = 0; p < NREQ; p++) begin
            req_q[p].delete();
            exp_q[p].delete();
            busy[p]     = 1'b0;
            clr_next[p] = 1'b0;
        end
        req_valid = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        flush_bench();
    endtask

    // Per-cycle step just after each rising edge: monitor, requester driver, slave.
    initial begin
        exp_t  e;
        stim_t s;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int unsigned p = 0; p < NREQ; p++)
                if (clr_next[p]) begin
                    busy[p]     = 1'b0;
                    clr_next[p] = 1'b0;
                end

            if (resp_valid != '0) begin
                check_eq("resp_onehot", 64'($onehot(resp_valid)), 64'd1);
                for (int unsigned p = 0; p < NREQ; p++) begin
                    if (resp_valid[p]) begin
                        if (exp_q[p].size() == 0) begin
                            check_eq("resp_spurious", 64'(p), 64'hFF);
                        end else begin
                            e = exp_q[p].pop_front();
                            check_eq("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
                            check_eq("resp_err", 64'(resp_err), 64'(e.err));
                            if (e.lat != 0)
                                check_eq("resp_latency", 64'(cyc - raise_cyc[p]), 64'(e.lat));
                            resp_order.push_back(p);
                            clr_next[p] = 1'b1;
                        end
                    end
                end
            end

            for (int unsigned p = 0; p < NREQ; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    req_valid[p] = 1'b0;
                end else if (!req_valid[p] && !busy[p] && req_q[p].size() != 0) begin
                    s = req_q[p].pop_front();
                    req_valid[p]          = 1'b1;
                    req_we[p]             = s.we;
                    req_addr[32*p +: 32]  = s.addr;
                    req_wdata[32*p +: 32] = s.wdata;
                    req_wstrb[4*p +: 4]   = s.wstrb;
                    busy[p]      = 1'b1;
                    raise_cyc[p] = cyc;
                    e.rdata = s.we ? 32'h0 : rd_fn(s.addr);
                    e.err   = s.we ? (slv_bresp != 2'b00) : (slv_rresp != 2'b00);
                    e.lat   = s.lat;
                    exp_q[p].push_back(e);
                end
            end

            if (axi.arvalid) begin
                if (ar_cnt == 0) ar_addr0 = axi.araddr;
                else if (axi.araddr != ar_addr0) ar_unstable++;
                if (axi.rready) rready_early++;
                if (ar_cnt == ar_delay) begin
                    axi.arready = 1'b1;
                    rd_addr     = axi.araddr;
                end else begin
                    axi.arready = 1'b0;
                    ar_cnt++;
                    ar_hold++;
                end
            end else begin
                axi.arready = 1'b0;
                ar_cnt      = 0;
            end

            if (axi.rready && r_cnt == r_delay) begin
                axi.rvalid = 1'b1;
                axi.rdata  = rd_fn(rd_addr);
                axi.rresp  = slv_rresp;
            end else begin
                axi.rvalid = 1'b0;
                axi.rdata  = '0;
                axi.rresp  = 2'b00;
                r_cnt      = axi.rready ? r_cnt + 1 : 0;
            end

            if (axi.awvalid) begin
                if (aw_cnt == aw_delay) begin
                    axi.awready = 1'b1;
                    seen_awaddr = axi.awaddr;
                end else begin
                    axi.awready = 1'b0;
                    aw_cnt++;
                end
            end else begin
                axi.awready = 1'b0;
                aw_cnt      = 0;
            end

            if (axi.wvalid) begin
                if (w_cnt == w_delay) begin
                    axi.wready    = 1'b1;
                    seen_wdata    = axi.wdata;
                    seen_wstrb    = axi.wstrb;
                    seen_aw_first = !axi.awvalid;
                    hs_cyc        = cyc;
                end else begin
                    axi.wready = 1'b0;
                    w_cnt++;
                    w_hold++;
                end
            end else begin
                axi.wready = 1'b0;
                w_cnt      = 0;
            end

            if (axi.bready && !bready_prev) bready_cyc = cyc;
            bready_prev = axi.bready;
            if (axi.bready && b_cnt == b_delay) begin
                axi.bvalid = 1'b1;
                axi.bresp  = slv_bresp;
            end else begin
                axi.bvalid = 1'b0;
                axi.bresp  = 2'b00;
                b_cnt      = axi.bready ? b_cnt + 1 : 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
        flush_bench();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("rst_axi_valid", 64'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}), 64'd0);
        check_eq("rst_req_resp", 64'({req_ready, resp_valid}), 64'd0);
        check_eq("rst_addr", {axi.araddr, axi.awaddr}, 64'd0);
        check_eq("rst_wdata_prot", 64'({axi.wdata, axi.wstrb, axi.arprot, axi.awprot}), 64'd0);
        check_eq("rst_resp_data", 64'({resp_rdata, resp_err}), 64'd0);

        // Zero-wait read from port 1.
        push_req(1, 1'b0, 32'h100, 32'h0, 4'h0, 3);
        wait_idle(50);

        // Both ports stream reads after reset: grants alternate starting at port 1.
        do_reset();
        resp_order.delete();
        push_req(0, 1'b0, 32'h400, 32'h0, 4'h0, 0);
        push_req(0, 1'b0, 32'h404, 32'h0, 4'h0, 0);
        push_req(1, 1'b0, 32'h500, 32'h0, 4'h0, 0);
        push_req(1, 1'b0, 32'h504, 32'h0, 4'h0, 0);
        wait_idle(200);
        check_eq("rr_count", 64'(resp_order.size()), 64'd4);
        if (resp_order.size() == 4)
            check_eq("rr_order", 64'({resp_order[0][0], resp_order[1][0], resp_order[2][0], resp_order[3][0]}), 64'b1010);

        // Write with awready two cycles ahead of wready and a SLVERR response.
        aw_delay = 0; w_delay = 2; slv_bresp = 2'b10; w_hold = 0;
        push_req(0, 1'b1, 32'h200, 32'h1234_5678, 4'b0011, 5);
        wait_idle(50);
        check_eq("wr_awaddr", 64'(seen_awaddr), 64'h200);
        check_eq("wr_wdata", 64'(seen_wdata), 64'h1234_5678);
        check_eq("wr_wstrb", 64'(seen_wstrb), 64'b0011);
        check_eq("wr_aw_first", 64'(seen_aw_first), 64'd1);
        check_eq("wr_w_hold", 64'(w_hold), 64'd2);
        slv_bresp = 2'b00; w_delay = 0;

        // Slave stalls arready for five cycles.
        ar_delay = 5; ar_hold = 0; ar_unstable = 0; rready_early = 0;
        push_req(0, 1'b0, 32'h600, 32'h0, 4'h0, 8);
        wait_idle(50);
        check_eq("ar_hold_cycles", 64'(ar_hold), 64'd5);
        check_eq("ar_stable", 64'(ar_unstable), 64'd0);
        check_eq("rready_early", 64'(rready_early), 64'd0);
        ar_delay = 0;

        // Address and data accepted together with the first valid cycle.
        push_req(1, 1'b1, 32'h700, 32'hCAFE_F00D, 4'b1111, 3);
        wait_idle(50);
        check_eq("wr_bready_gap", 64'(bready_cyc - hs_cyc), 64'd1);
        check_eq("wr_awaddr_same", 64'(seen_awaddr), 64'h700);
        check_eq("wr_wdata_same", 64'(seen_wdata), 64'hCAFE_F00D);

        // Reset lands while a port-1 read waits in RD_DATA.
        r_delay = 50;
        push_req(1, 1'b0, 32'h300, 32'h0, 4'h0, 0);
        n = 0;
        while (!axi.rready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_mid_rd_reached", 64'(axi.rready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check_eq("rst_mid_axi", 64'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}), 64'd0);
        check_eq("rst_mid_resp", 64'({resp_valid, req_ready}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        flush_bench();
        r_delay = 0;
        resp_order.delete();
        push_req(0, 1'b0, 32'h800, 32'h0, 4'h0, 0);
        push_req(1, 1'b0, 32'h900, 32'h0, 4'h0, 0);
        wait_idle(100);
        check_eq("rst_ptr_count", 64'(resp_order.size()), 64'd2);
        if (resp_order.size() == 2)
            check_eq("rst_ptr_order", 64'({resp_order[0][0], resp_order[1][0]}), 64'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
